// File: rtl/ro_meas_pkg.sv
// rtl/ro_meas_pkg.sv - shared state type and constants for RO measurement
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        GATE    = 2'd2,
        CAPTURE = 2'd3
    } measState_t;

    localparam int ARM_CYCLES    = 2;
    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - 3-flop synchronizer and rising-edge detector for one RO channel
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic roEdge
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign roEdge = s2 & ~s3;

endmodule

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - gated RO edge counter feeding the BCD conversion stage
module ro_edge_counter
    import ro_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int          CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] count,
    output logic             start,
    output logic             overflow,
    output logic             busy
);

    // Two spare bits keep the ARM phase countable even when GATE_CYCLES is 1.
    localparam int WIN_W = $clog2(GATE_CYCLES) + 2;
    localparam logic [WIN_W-1:0] GATE_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [WIN_W-1:0] ARM_LAST  = WIN_W'(ARM_CYCLES - 1);

    measState_t       state, nextState;
    logic [WIN_W-1:0] winCnt;
    logic [CNT_W-1:0] acc;
    logic             sat;
    logic             roEdge;

    ro_edge_sync uSync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_in),
        .roEdge   (roEdge)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (en) nextState = ARM;
            ARM:     if (!en) nextState = IDLE;
                     else if (winCnt == ARM_LAST) nextState = GATE;
            GATE:    if (!en) nextState = IDLE;
                     else if (winCnt == GATE_LAST) nextState = CAPTURE;
            CAPTURE: nextState = en ? ARM : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ARM) || (state == GATE);
    end

    // The window counter restarts on every state change, so it times both ARM and GATE.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || nextState != state) winCnt <= '0;
        else                                             winCnt <= winCnt + WIN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || state == ARM) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (state == GATE && roEdge) begin
            if (acc == '1) sat <= 1'b1;
            else           acc <= acc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
            start    <= 1'b0;
        end else begin
            start <= (state == CAPTURE);
            if (state == CAPTURE) begin
                count    <= acc;
                overflow <= sat;
            end
        end
    end

endmodule

// File: doc/ro_edge_counter.md
# ro_edge_counter

Measurement front end of the delay-based Trojan detection path. Counts rising edges of a ring-oscillator (RO) signal over a fixed gate window of system-clock cycles, latches the 32-bit result, and issues a start pulse to the decimal/BCD conversion stage that follows it. The latched count and start pulse feed that stage's `A` and `start` inputs directly.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles; legal range 1 to 2^32-1.
- `CNT_W`, default 32: count width; must match the converter input width.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  level; high runs continuous measurements, low stops after abort (see Operation).
- `ro_in`  in  1  RO output; asynchronous to `clk`; frequency must be below `clk`/2.
- `count`  out  CNT_W  last captured edge count; holds until the next capture.
- `start`  out  1  one-cycle pulse in the cycle `count` takes a new value.
- `overflow`  out  1  captured with `count`; high if the window count saturated.
- `busy`  out  1  high in ARM and GATE.

## Operation
- Reset values: `count` = 0, `start` = 0, `overflow` = 0, `busy` = 0, state IDLE, all synchronizer flops 0.
- Edge detection: 3-flop chain s1→s2→s3 on `ro_in`; `edge` = s2 & ~s3. Edges are counted only in GATE.
- FSM:
  - IDLE: `en`=1 → ARM.
  - ARM: lasts 2 cycles (ARM_CYCLES); clears the window counter and the edge accumulator; flushes stale synchronizer state. `en`=0 → IDLE.
  - GATE: lasts exactly GATE_CYCLES cycles; accumulator += `edge` each cycle. `en`=0 → IDLE with no capture, and `count`/`overflow` keep their old values.
  - CAPTURE: 1 cycle. The accumulator value is registered into `count`; `start` and `overflow` are registered in the same edge, so all three are valid the cycle after CAPTURE. Next state: ARM if `en`, else IDLE.
- Saturation: the accumulator stops at 2^CNT_W-1 and sets a sticky saturation flag, which is cleared in ARM and copied to `overflow` at capture.
- Simultaneous events:
  - `en` falling in the CAPTURE cycle: the capture still completes, then the FSM goes to IDLE.
  - An edge in the final GATE cycle is counted.
- A mid-operation `rst` abandons the window. Outputs return to their reset values on the next cycle.

## Timing
- `en` first sampled high at edge 0 gives: ARM on cycles 1–2, GATE on cycles 3 .. 2+GATE_CYCLES, CAPTURE on cycle 3+GATE_CYCLES. `start`, `count` and `overflow` are updated on cycle 4+GATE_CYCLES.
- Continuous period: 3+GATE_CYCLES cycles per measurement (ARM 2 + GATE + CAPTURE 1).
- `ro_in` to `edge`: 2–3 `clk` edges. An RO rise within 2 cycles before GATE ends may fall into the next window; this is accepted.
- `start` is never high on two consecutive cycles. `count` never changes except alongside `start`, or on `rst`.

## Structure
- Shared package `ro_meas_pkg` holds:
  - the state enum: IDLE, ARM, GATE, CAPTURE;
  - `ARM_CYCLES` = 2;
  - the default `CNT_W` = 32.
- Sub-module `ro_edge_sync` holds the 3-flop synchronizer and rising-edge detector (`clk`, `rst`, `async_in` → `edge`). It is reused for every RO channel.
- The top level holds the FSM, the window counter (width ≥ clog2(GATE_CYCLES)+1), the saturating accumulator, and the output registers.

## Test plan
- Reset: assert `rst` with `ro_in` toggling → all outputs 0, and `busy` is 0 on the cycle after `rst`.
- GATE_CYCLES=100, `ro_in` period 10 clk, `en` held → `start` pulses every 103 cycles with `count` in 9..11 each time; the first pulse lands on cycle 104 after `en`.
- GATE_CYCLES=100, `ro_in` tied 0 → `count`=0, `overflow`=0 at each pulse. Then `ro_in` period 4 → `count` in 24..26.
- CNT_W=4, GATE_CYCLES=100, `ro_in` period 4 → `count`=15, `overflow`=1. A following window with `ro_in` period 20 → `count` in 4..6 and `overflow`=0.
- `en` dropped at GATE cycle 50 → no `start`, `count` keeps its previous value, `busy`=0 one cycle later. Re-asserting `en` gives a full 103-cycle period.
- `rst` pulsed mid-GATE with `en` still high → outputs cleared. The next `start` occurs 104 cycles after `rst` is released.
